trigger_pulse_seq: RTL and testbench

TRIGGER_PULSE_SEQ -- requirements
Module: trigger_pulse_seq

---
 rtl/trigger_pulse_seq.sv | 134 +++++++++++++
 tb/tb_trigger_pulse_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_pulse_seq.sv
// Triggered burst generator: after a programmable delay, emits count pulses of
// width cycles separated by gap cycles; parameters are latched at trigger time.
module trigger_pulse_seq #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger2,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic [REP_W-1:0] count,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [REP_W-1:0] rep, rep_n;
    logic [CNT_W-1:0] lat_delay, lat_delay_n;
    logic [CNT_W-1:0] lat_width, lat_width_n;
    logic [CNT_W-1:0] lat_gap, lat_gap_n;
    logic             pulse_n, busy_n, done_n, overrun_n;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rep_n       = rep;
        lat_delay_n = lat_delay;
        lat_width_n = lat_width;
        lat_gap_n   = lat_gap;
        pulse_n     = pulse_out;
        busy_n      = busy;
        done_n      = 1'b0;
        overrun_n   = overrun;

        unique case (state)
            IDLE: begin
                if (trigger2 && width != '0 && count != '0) begin
                    lat_delay_n = delay;
                    lat_width_n = width;
                    lat_gap_n   = gap;
                    rep_n       = count;
                    busy_n      = 1'b1;
                    // zero delay goes straight to the first high cycle
                    if (delay == '0) begin
                        state_n = HIGH;
                        cnt_n   = width;
                        pulse_n = 1'b1;
                    end else begin
                        state_n = DELAY;
                        cnt_n   = delay;
                    end
                end
            end
            DELAY: begin
                if (cnt == CNT_ONE) begin
                    state_n = HIGH;
                    cnt_n   = lat_width;
                    pulse_n = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            HIGH: begin
                if (cnt == CNT_ONE) begin
                    pulse_n = 1'b0;
                    if (rep == REP_ONE) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        rep_n   = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = LOW;
                        cnt_n   = (lat_gap == '0) ? CNT_ONE : lat_gap;
                        rep_n   = rep - REP_ONE;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            LOW: begin
                if (cnt == CNT_ONE) begin
                    state_n = HIGH;
                    cnt_n   = lat_width;
                    pulse_n = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state != IDLE && trigger2) begin
            overrun_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rep       <= '0;
            lat_delay <= '0;
            lat_width <= '0;
            lat_gap   <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rep       <= rep_n;
            lat_delay <= lat_delay_n;
            lat_width <= lat_width_n;
            lat_gap   <= lat_gap_n;
            pulse_out <= pulse_n;
            busy      <= busy_n;
            done      <= done_n;
            overrun   <= overrun_n;
        end
    end

endmodule

// File: tb/tb_trigger_pulse_seq.sv
// Directed bench for trigger_pulse_seq; narrowed fields let all-ones values run to completion.
module tb_trigger_pulse_seq;

    localparam int CNT_W = 8;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             trigger2;
    logic [CNT_W-1:0] delay, width, gap;
    logic [REP_W-1:0] count;
    logic             pulse_out, busy, done, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // bit k holds the output seen in cycle T+k, where T is the trigger cycle
    logic [63:0] cap_p, cap_b, cap_d;

    trigger_pulse_seq #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .trigger2 (trigger2),
        .delay    (delay),
        .width    (width),
        .gap      (gap),
        .count    (count),
        .pulse_out(pulse_out),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mask(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // trigger2 must already be high for cycle T when this is called
    task automatic capture(input int n, input int trig_at, input int chg_at,
                           input logic [CNT_W-1:0] nd, input logic [CNT_W-1:0] nw);
        cap_p = '0;
        cap_b = '0;
        cap_d = '0;
        for (int k = 1; k <= n; k++) begin
            tick();
            trigger2 = (k == trig_at);
            if (k == chg_at) begin
                delay = nd;
                width = nw;
            end
            cap_p[k] = pulse_out;
            cap_b[k] = busy;
            cap_d[k] = done;
        end
        trigger2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; trigger2 = 1'b0;
        delay = '0; width = '0; gap = '0; count = '0;
        tick(); tick();
        n_checks++; if (pulse_out !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", pulse_out); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        delay = 3; width = 2; gap = 4; count = 3;
        trigger2 = 1'b1;
        capture(24, 0, 0, '0, '0);
        n_checks++; if (cap_p !== (mask(4,5) | mask(10,11) | mask(16,17)))
            begin n_fail++; $display("FAIL basic_pulse: got %h expected %h", cap_p, mask(4,5) | mask(10,11) | mask(16,17)); end
        n_checks++; if (cap_b !== mask(1,17))  begin n_fail++; $display("FAIL basic_busy: got %h expected %h", cap_b, mask(1,17)); end
        n_checks++; if (cap_d !== mask(18,18)) begin n_fail++; $display("FAIL basic_done: got %h expected %h", cap_d, mask(18,18)); end
        n_checks++; if (overrun !== 1'b0)      begin n_fail++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_zero_delay();
        delay = 0; width = 1; gap = 0; count = 2;
        trigger2 = 1'b1;
        capture(8, 0, 0, '0, '0);
        n_checks++; if (cap_p !== (mask(1,1) | mask(3,3))) begin n_fail++; $display("FAIL zd_pulse: got %h expected %h", cap_p, mask(1,1) | mask(3,3)); end
        n_checks++; if (cap_b !== mask(1,3)) begin n_fail++; $display("FAIL zd_busy: got %h expected %h", cap_b, mask(1,3)); end
        n_checks++; if (cap_d !== mask(4,4)) begin n_fail++; $display("FAIL zd_done: got %h expected %h", cap_d, mask(4,4)); end
    endtask

    task automatic test_ignored();
        delay = 1; width = 0; gap = 1; count = 3;
        trigger2 = 1'b1;
        capture(6, 0, 0, '0, '0);
        n_checks++; if ((cap_p | cap_b | cap_d) !== 64'd0) begin n_fail++; $display("FAIL ign_width0: got p=%h b=%h d=%h expected all 0", cap_p, cap_b, cap_d); end
        width = 2; count = 0;
        trigger2 = 1'b1;
        capture(6, 0, 0, '0, '0);
        n_checks++; if ((cap_p | cap_b | cap_d) !== 64'd0) begin n_fail++; $display("FAIL ign_count0: got p=%h b=%h d=%h expected all 0", cap_p, cap_b, cap_d); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ign_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_overrun();
        delay = 1; width = 2; gap = 1; count = 2;
        trigger2 = 1'b1;
        capture(12, 3, 0, '0, '0);
        n_checks++; if (cap_p !== (mask(2,3) | mask(5,6))) begin n_fail++; $display("FAIL ovr_pulse: got %h expected %h", cap_p, mask(2,3) | mask(5,6)); end
        n_checks++; if (cap_b !== mask(1,6)) begin n_fail++; $display("FAIL ovr_busy: got %h expected %h", cap_b, mask(1,6)); end
        n_checks++; if (cap_d !== mask(7,7)) begin n_fail++; $display("FAIL ovr_done: got %h expected %h", cap_d, mask(7,7)); end
        n_checks++; if (overrun !== 1'b1)    begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (overrun !== 1'b1)    begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if (overrun !== 1'b0)    begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        tick();
    endtask

    task automatic test_back_to_back();
        delay = 0; width = 1; gap = 0; count = 1;
        trigger2 = 1'b1;
        capture(8, 2, 0, '0, '0);
        n_checks++; if (cap_p !== (mask(1,1) | mask(3,3))) begin n_fail++; $display("FAIL b2b_pulse: got %h expected %h", cap_p, mask(1,1) | mask(3,3)); end
        n_checks++; if (cap_b !== (mask(1,1) | mask(3,3))) begin n_fail++; $display("FAIL b2b_busy: got %h expected %h", cap_b, mask(1,1) | mask(3,3)); end
        n_checks++; if (cap_d !== (mask(2,2) | mask(4,4))) begin n_fail++; $display("FAIL b2b_done: got %h expected %h", cap_d, mask(2,2) | mask(4,4)); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_mid_reset();
        int dones;
        int busys;
        delay = 3; width = 2; gap = 4; count = 3;
        trigger2 = 1'b1;
        tick(); trigger2 = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (pulse_out !== 1'b1) begin n_fail++; $display("FAIL mr_high_before: got %b expected 1", pulse_out); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if (pulse_out !== 1'b0) begin n_fail++; $display("FAIL mr_pulse: got %b expected 0", pulse_out); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mr_busy: got %b expected 0", busy); end
        dones = 0; busys = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            if (busy) busys++;
            tick();
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL mr_no_done: got %0d done cycles expected 0", dones); end
        n_checks++; if (busys !== 0) begin n_fail++; $display("FAIL mr_stays_idle: got %0d busy cycles expected 0", busys); end
        rst = 1'b1; trigger2 = 1'b1;
        tick();
        rst = 1'b0; trigger2 = 1'b0;
        busys = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy | pulse_out) busys++;
        end
        n_checks++; if (busys !== 0) begin n_fail++; $display("FAIL rst_drops_trig: got %0d active cycles expected 0", busys); end
        trigger2 = 1'b1;
        capture(24, 0, 0, '0, '0);
        n_checks++; if (cap_p !== (mask(4,5) | mask(10,11) | mask(16,17)))
            begin n_fail++; $display("FAIL mr_retrig_pulse: got %h expected %h", cap_p, mask(4,5) | mask(10,11) | mask(16,17)); end
        n_checks++; if (cap_d !== mask(18,18)) begin n_fail++; $display("FAIL mr_retrig_done: got %h expected %h", cap_d, mask(18,18)); end
    endtask

    task automatic test_mid_change();
        delay = 3; width = 2; gap = 4; count = 3;
        trigger2 = 1'b1;
        capture(24, 0, 5, 8'd1, 8'd3);
        n_checks++; if (cap_p !== (mask(4,5) | mask(10,11) | mask(16,17)))
            begin n_fail++; $display("FAIL mc_pulse: got %h expected %h", cap_p, mask(4,5) | mask(10,11) | mask(16,17)); end
        n_checks++; if (cap_b !== mask(1,17))  begin n_fail++; $display("FAIL mc_busy: got %h expected %h", cap_b, mask(1,17)); end
        n_checks++; if (cap_d !== mask(18,18)) begin n_fail++; $display("FAIL mc_done: got %h expected %h", cap_d, mask(18,18)); end
        count = 1;
        trigger2 = 1'b1;
        capture(10, 0, 0, '0, '0);
        n_checks++; if (cap_p !== mask(2,4)) begin n_fail++; $display("FAIL mc_next_pulse: got %h expected %h", cap_p, mask(2,4)); end
        n_checks++; if (cap_d !== mask(5,5)) begin n_fail++; $display("FAIL mc_next_done: got %h expected %h", cap_d, mask(5,5)); end
    endtask

    task automatic test_max();
        int first_rise, highs, rises, done_at;
        logic prev;
        delay = '1; width = '1; gap = '1; count = '1;
        first_rise = -1; highs = 0; rises = 0; done_at = -1; prev = 1'b0;
        trigger2 = 1'b1;
        for (int k = 1; k <= 8000; k++) begin
            tick();
            trigger2 = 1'b0;
            if (pulse_out) highs++;
            if (pulse_out && !prev) begin
                rises++;
                if (first_rise < 0) first_rise = k;
            end
            prev = pulse_out;
            if (done) begin
                done_at = k;
                break;
            end
        end
        n_checks++; if (done_at !== 7651)    begin n_fail++; $display("FAIL max_done_cycle: got %0d expected 7651", done_at); end
        n_checks++; if (first_rise !== 256)  begin n_fail++; $display("FAIL max_first_rise: got %0d expected 256", first_rise); end
        n_checks++; if (highs !== 3825)      begin n_fail++; $display("FAIL max_high_cycles: got %0d expected 3825", highs); end
        n_checks++; if (rises !== 15)        begin n_fail++; $display("FAIL max_pulse_count: got %0d expected 15", rises); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL max_busy_at_done: got %b expected 0", busy); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_delay();
        test_ignored();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        test_mid_change();
        test_max();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
